// File: rtl/pingpong_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_bank_buffer
// Description : Two-bank ping-pong frame buffer. The writer fills one bank
//               while the consumer reads the other; the banks swap once
//               the read bank has been released.
//               Optional dropped-write counter: define PINGPONG_OVF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_bank_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_wr_vld,
   output logic              o_wr_rdy,
   output logic              o_wr_bank,
   output logic              o_bank_rdy,
   input  logic              i_rd_done,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_vld
`ifdef PINGPONG_OVF_CNT_EN
   ,
   output logic [15:0]       o_ovf_cnt
`endif
);

   localparam int              c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_WAIT = 2'd1,
      S_SWAP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_wr_bank;
   logic [ADDR_W-1:0]   r_wr_cnt;
   logic [1:0]          r_full;
   logic [DATA_W-1:0]   r_mem [2][DEPTH];
   logic                w_rd_bank;
   logic                w_wr_fire;
   logic                w_wr_last;
   logic                w_rd_clr;
   logic                w_rd_ok;

   assign w_rd_bank  = ~r_wr_bank;
   assign o_wr_bank  = r_wr_bank;
   assign o_bank_rdy = r_full[w_rd_bank];
   assign w_wr_fire  = (r_state == S_FILL) & i_wr_vld;
   assign w_wr_last  = w_wr_fire & (r_wr_cnt == c_last);
   assign w_rd_clr   = i_rd_done & o_bank_rdy;
   assign w_rd_ok    = i_rd_en & o_bank_rdy & ({1'b0, i_rd_addr} < c_depth);

   // Swap decisions look at the registered full flag, so a release arriving
   // together with the final write still costs one WAIT cycle.
   always_comb begin
      w_state_nxt = r_state;
      o_wr_rdy    = 1'b0;
      case (r_state)
         S_FILL: begin
            o_wr_rdy = 1'b1;
            if (w_wr_last) begin
               w_state_nxt = r_full[w_rd_bank] ? S_WAIT : S_SWAP;
            end
         end
         S_WAIT: begin
            if (!r_full[w_rd_bank]) begin
               w_state_nxt = S_SWAP;
            end
         end
         S_SWAP:  w_state_nxt = S_FILL;
         default: w_state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_FILL;
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= '0;
         r_full    <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         if (w_wr_fire) begin
            r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + ADDR_W'(1);
         end
         if (w_wr_last) begin
            r_full[r_wr_bank] <= 1'b1;
         end
         if (w_rd_clr) begin
            r_full[w_rd_bank] <= 1'b0;
         end
         if (r_state == S_SWAP) begin
            r_wr_bank <= ~r_wr_bank;
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge i_clk) begin
      if (w_wr_fire) begin
         r_mem[r_wr_bank][r_wr_cnt[c_idx_w-1:0]] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rd_data <= '0;
         o_rd_vld  <= 1'b0;
      end else begin
         o_rd_vld <= w_rd_ok;
         if (w_rd_ok) begin
            o_rd_data <= r_mem[w_rd_bank][i_rd_addr[c_idx_w-1:0]];
         end
      end
   end

`ifdef PINGPONG_OVF_CNT_EN
   logic [15:0] r_ovf_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ovf_cnt <= '0;
      end else if (i_wr_vld && !o_wr_rdy && (r_ovf_cnt != 16'hFFFF)) begin
         r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
   end

   assign o_ovf_cnt = r_ovf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pingpong_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pingpong_bank_buffer
// Description : Scoreboard bench for pingpong_bank_buffer (DEPTH=4, DATA_W=8)
//               with directed frames followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_bank_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] wr_data = '0;
   logic          wr_vld = 1'b0;
   logic          wr_rdy;
   logic          wr_bank;
   logic          bank_rdy;
   logic          rd_done = 1'b0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          rd_vld;
`ifdef PINGPONG_OVF_CNT_EN
   logic [15:0]   ovf_cnt;
`endif

   always #5 clk = ~clk;

   pingpong_bank_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_data  (wr_data),
      .i_wr_vld   (wr_vld),
      .o_wr_rdy   (wr_rdy),
      .o_wr_bank  (wr_bank),
      .o_bank_rdy (bank_rdy),
      .i_rd_done  (rd_done),
      .i_rd_en    (rd_en),
      .i_rd_addr  (rd_addr),
      .o_rd_data  (rd_data),
      .o_rd_vld   (rd_vld)
`ifdef PINGPONG_OVF_CNT_EN
      ,
      .o_ovf_cnt  (ovf_cnt)
`endif
   );

   typedef struct {
      logic          vld;
      logic [DW-1:0] data;
      logic          wr_rdy;
      logic          wr_bank;
      logic          bank_rdy;
      logic [15:0]   ovf;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: frame-level view of the two banks.
   logic [DW-1:0] m_mem [2][DEPTH];
   int            m_bank = 0;
   int            m_cnt = 0;
   bit            m_full [2] = '{0, 0};
   bit            m_stall = 0;   // frame complete, writer blocked
   bit            m_pending = 0; // next cycle performs the bank swap
   logic [DW-1:0] m_data = '0;
   int            m_ovf = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("rd_vld", 16'(rd_vld), 16'(e.vld));
         chk("rd_data", 16'(rd_data), 16'(e.data));
         chk("wr_rdy", 16'(wr_rdy), 16'(e.wr_rdy));
         chk("wr_bank", 16'(wr_bank), 16'(e.wr_bank));
         chk("bank_rdy", 16'(bank_rdy), 16'(e.bank_rdy));
`ifdef PINGPONG_OVF_CNT_EN
         chk("ovf_cnt", ovf_cnt, e.ovf);
`endif
      end
   end

   task automatic cycle(input bit r, input bit wv, input logic [DW-1:0] wd,
                        input bit done, input bit re, input logic [AW-1:0] addr);
      exp_t e;
      int   rb;
      bit   full_rb;
      bit   was_stall;
      @(negedge clk);
      #1;
      rst = r; wr_vld = wv; wr_data = wd; rd_done = done; rd_en = re; rd_addr = addr;
      e.vld = 1'b0;
      if (r) begin
         m_bank = 0; m_cnt = 0; m_full = '{0, 0};
         m_stall = 0; m_pending = 0; m_data = '0; m_ovf = 0;
      end else begin
         rb        = 1 - m_bank;
         full_rb   = m_full[rb];
         was_stall = m_stall;
         if (re && addr < DEPTH && full_rb) begin
            e.vld  = 1'b1;
            m_data = m_mem[rb][addr];
         end
         if (!was_stall && wv) begin
            m_mem[m_bank][m_cnt] = wd;
            m_cnt++;
            if (m_cnt == DEPTH) begin
               m_cnt          = 0;
               m_full[m_bank] = 1;
               m_stall        = 1;
               m_pending      = !full_rb;
            end
         end else if (was_stall) begin
            if (wv && m_ovf < 65535) m_ovf++;
            if (m_pending) begin
               m_bank    = rb;
               m_stall   = 0;
               m_pending = 0;
            end else if (!full_rb) begin
               m_pending = 1;
            end
         end
         if (done && full_rb) m_full[rb] = 0;
      end
      e.data     = m_data;
      e.wr_rdy   = !m_stall;
      e.wr_bank  = 1'(m_bank);
      e.bank_rdy = m_full[1 - m_bank];
      e.ovf      = 16'(m_ovf);
      sb.push_back(e);
   endtask

   task automatic idle();
      cycle(0, 0, '0, 0, 0, '0);
   endtask

   initial begin
      cycle(1, 0, '0, 0, 0, '0);
      cycle(1, 0, '0, 0, 0, '0);

      // First frame into bank 0, then read it back.
      for (int i = 0; i < 4; i++) cycle(0, 1, DW'(8'h10 + i), 0, 0, '0);
      idle();
      for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 1, AW'(i));

      // Bank 1 fills while bank 0 is still held; writes during WAIT are dropped.
      for (int i = 0; i < 4; i++) cycle(0, 1, DW'(8'h20 + i), 0, 0, '0);
      repeat (5) cycle(0, 1, 8'hEE, 0, 0, '0);
      cycle(0, 0, '0, 1, 0, '0);
      idle();
      idle();
      for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 1, AW'(i));

      // Final write coincides with the release.
      for (int i = 0; i < 3; i++) cycle(0, 1, DW'(8'h30 + i), 0, 0, '0);
      cycle(0, 1, 8'h33, 1, 0, '0);
      idle();
      idle();
      idle();
      for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 1, AW'(i));

      // Out-of-range read, then reset in the middle of a frame.
      cycle(0, 0, '0, 0, 1, AW'(4));
      cycle(0, 1, 8'h55, 0, 0, '0);
      cycle(0, 1, 8'h56, 0, 0, '0);
      cycle(1, 1, 8'h57, 1, 1, '0);
      for (int i = 0; i < 4; i++) cycle(0, 1, DW'(8'h40 + i), 0, 0, '0);
      idle();
      for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 1, AW'(i));

      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 9) < 6),
               DW'($urandom),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 1) == 1),
               AW'($urandom_range(0, 5)));
      end
      idle();

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
